muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative RV32M-style multiply/divide unit, one bit per cycle.
//  Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  ALU_Control,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             op_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(6'b010011);
    localparam logic [OP_W-1:0] OP_DIV    = OP_W'(6'b010100);
    localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(6'b010101);
    localparam logic [OP_W-1:0] OP_REM    = OP_W'(6'b010110);
    localparam logic [OP_W-1:0] OP_REMU   = OP_W'(6'b010111);

    localparam logic [1:0] K_MUL_LO = 2'd0;
    localparam logic [1:0] K_MUL_HI = 2'd1;
    localparam logic [1:0] K_QUO    = 2'd2;
    localparam logic [1:0] K_REM    = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ready_q;
    logic   pend_q;

    logic [2*WIDTH:0]  acc_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        kind_q;
    logic              neg_q;
    logic              is_div_q;
    logic              fast_q;
    logic [WIDTH-1:0]  res_q;
    logic              err_q;

    logic              w_accept;
    logic              w_is_mul, w_is_div, w_a_signed, w_b_signed;
    logic [1:0]        w_kind;
    logic              w_a_neg, w_b_neg, w_neg_res;
    logic [WIDTH-1:0]  w_mag_a, w_mag_b;
    logic              w_dz, w_ovf, w_unsup, w_fast;
    logic [WIDTH-1:0]  w_fast_res;

    logic [WIDTH:0]    w_mul_sum;
    logic [2*WIDTH:0]  w_mul_next;
    logic [WIDTH+1:0]  w_trial;
    logic [2*WIDTH:0]  w_div_next;
    logic [2*WIDTH:0]  w_acc_next;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]  w_quo, w_quo_s, w_rem, w_rem_s;
    logic [WIDTH-1:0]  w_fix_res;

    // ------------------------------------------------------------------ decode
    always_comb begin
        w_is_mul   = 1'b0;
        w_is_div   = 1'b0;
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        w_kind     = K_MUL_LO;
        case (ALU_Control)
            OP_MUL:    w_is_mul = 1'b1;
            OP_MULH:   begin w_is_mul = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_kind = K_MUL_HI; end
            OP_MULHSU: begin w_is_mul = 1'b1; w_a_signed = 1'b1; w_kind = K_MUL_HI; end
            OP_MULHU:  begin w_is_mul = 1'b1; w_kind = K_MUL_HI; end
            OP_DIV:    begin w_is_div = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_kind = K_QUO; end
            OP_DIVU:   begin w_is_div = 1'b1; w_kind = K_QUO; end
            OP_REM:    begin w_is_div = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_kind = K_REM; end
            OP_REMU:   begin w_is_div = 1'b1; w_kind = K_REM; end
            default:   ;
        endcase
    end

    assign w_a_neg   = w_a_signed & operand_A[WIDTH-1];
    assign w_b_neg   = w_b_signed & operand_B[WIDTH-1];
    // Remainder follows the dividend's sign; every other result the sign product.
    assign w_neg_res = (w_kind == K_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_mag_a   = w_a_neg ? -operand_A : operand_A;
    assign w_mag_b   = w_b_neg ? -operand_B : operand_B;

    assign w_dz    = w_is_div & (operand_B == '0);
    assign w_ovf   = w_is_div & w_a_signed
                   & (operand_A == {1'b1, {(WIDTH-1){1'b0}}})
                   & (operand_B == '1);
    assign w_unsup = ~(w_is_mul | w_is_div);
    assign w_fast  = w_unsup | w_dz | w_ovf;

    always_comb begin
        w_fast_res = '0;
        if (w_dz) begin
            w_fast_res = (w_kind == K_REM) ? operand_A : '1;
        end else if (w_ovf) begin
            w_fast_res = (w_kind == K_REM) ? '0 : operand_A;
        end
    end

    // ------------------------------------------------------- iteration steps
    // Multiply: acc = {upper partial sum, remaining multiplier bits}, shift right.
    assign w_mul_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_next = {1'b0, w_mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shift left.
    assign w_trial    = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    assign w_div_next = w_trial[WIDTH+1] ? {acc_q[2*WIDTH-1:0], 1'b0}
                                         : {w_trial[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
    assign w_acc_next = is_div_q ? w_div_next : w_mul_next;

    assign w_prod   = w_acc_next[2*WIDTH-1:0];
    assign w_prod_s = neg_q ? -w_prod : w_prod;
    assign w_quo    = w_acc_next[WIDTH-1:0];
    assign w_rem    = w_acc_next[2*WIDTH-1:WIDTH];
    assign w_quo_s  = neg_q ? -w_quo : w_quo;
    assign w_rem_s  = neg_q ? -w_rem : w_rem;

    always_comb begin
        w_fix_res = '0;
        case (kind_q)
            K_MUL_LO: w_fix_res = w_prod[WIDTH-1:0];
            K_MUL_HI: w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
            K_QUO:    w_fix_res = w_quo_s;
            K_REM:    w_fix_res = w_rem_s;
            default:  w_fix_res = '0;
        endcase
    end

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            pend_q  <= w_accept;
        end
    end

    // The accept cycle only captures operands; the path decision is taken one
    // edge later from the registered copy.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ready_q & ~pend_q;
                w_accept = ready_q & ~pend_q & in_valid;
                if (pend_q) begin
                    state_d = fast_q ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            kind_q   <= K_MUL_LO;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
            fast_q   <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else if (w_accept) begin
            acc_q    <= {{(WIDTH+1){1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            opnd_q   <= w_is_div ? w_mag_b : w_mag_a;
            cnt_q    <= '0;
            kind_q   <= w_kind;
            neg_q    <= w_neg_res;
            is_div_q <= w_is_div;
            fast_q   <= w_fast;
            res_q    <= w_fast_res;
            err_q    <= w_unsup;
        end else if (state_q == CALC) begin
            acc_q <= w_acc_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
                res_q <= w_fix_res;
            end
        end
    end

    assign ALU_result = (state_q == DONE) ? res_q : '0;
    assign op_err     = (state_q == DONE) & err_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Brief    : Directed self-checking bench for muldiv_unit (WIDTH 32 and 8).
//  Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

    localparam logic [5:0] MUL    = 6'b010000;
    localparam logic [5:0] MULH   = 6'b010001;
    localparam logic [5:0] MULHSU = 6'b010010;
    localparam logic [5:0] MULHU  = 6'b010011;
    localparam logic [5:0] DIV    = 6'b010100;
    localparam logic [5:0] DIVU   = 6'b010101;
    localparam logic [5:0] REM    = 6'b010110;
    localparam logic [5:0] REMU   = 6'b010111;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, ordy32, err32;
    logic [5:0]  op32;
    logic [31:0] a32, b32, r32;
    logic        iv8, ir8, ov8, ordy8, err8;
    logic [5:0]  op8;
    logic [7:0]  a8, b8, r8;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.WIDTH(32), .OP_W(6)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .ALU_Control(op32), .operand_A(a32), .operand_B(b32),
        .out_valid(ov32), .out_ready(ordy32), .ALU_result(r32), .op_err(err32)
    );

    muldiv_unit #(.WIDTH(8), .OP_W(6)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .ALU_Control(op8), .operand_A(a8), .operand_B(b8),
        .out_valid(ov8), .out_ready(ordy8), .ALU_result(r8), .op_err(err8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] get_res(input bit is8);
        return is8 ? {56'b0, r8} : {32'b0, r32};
    endfunction

    function automatic logic get_err(input bit is8);
        return is8 ? err8 : err32;
    endfunction

    task automatic drive(input bit is8, input logic v, input logic [5:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (is8) begin iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else begin iv32 = v; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
    endtask

    task automatic wait_valid(input bit is8, output int lat);
        lat = 0;
        while (!(is8 ? ov8 : ov32) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue one request (DUT idle and ready), scramble inputs after accept,
    // check latency/result/error, then let the result be consumed.
    task automatic run(input bit is8, input logic [5:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input logic exp_err, input int exp_lat, input string tag);
        int lat;
        drive(is8, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(is8, 1'b0, 6'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        wait_valid(is8, lat);
        check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "/res"}, get_res(is8), exp);
        check({tag, "/err"}, 64'(get_err(is8)), 64'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin : main
        int lat;
        int seen;
        reset = 1'b0;
        iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; ordy32 = 1'b1;
        iv8  = 1'b0; op8  = '0; a8  = '0; b8  = '0; ordy8  = 1'b1;

        #1 reset = 1'b1;
        #2;
        check("rst/in_ready", 64'(ir32), 64'd0);
        check("rst/out_valid", 64'(ov32), 64'd0);
        check("rst/result", get_res(1'b0), 64'd0);
        check("rst/op_err", 64'(err32), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst/in_ready_clk", 64'(ir32), 64'd0);
        #2 reset = 1'b0;
        #1;
        check("rst/ready_before_edge", 64'(ir32), 64'd0);
        @(posedge clk); #1;
        check("rst/ready_after_edge", 64'(ir32), 64'd1);
        check("rst/ready8_after_edge", 64'(ir8), 64'd1);

        // Normal-path multiply and divide, WIDTH=32
        run(1'b0, MUL,    64'd15,          64'd10,          64'd150,          1'b0, 33, "mul15x10");
        run(1'b0, MULH,   64'hFFFFFFFF,    64'hFFFFFFFF,    64'h0,            1'b0, 33, "mulh_m1");
        run(1'b0, MULHU,  64'hFFFFFFFF,    64'hFFFFFFFF,    64'hFFFFFFFE,     1'b0, 33, "mulhu_max");
        run(1'b0, MULHSU, 64'hFFFFFFFF,    64'd2,           64'hFFFFFFFF,     1'b0, 33, "mulhsu");
        run(1'b0, MUL,    64'hFFFFFFFF,    64'hFFFFFFFF,    64'h1,            1'b0, 33, "mul_lo_max");
        run(1'b0, MULH,   64'h80000000,    64'h80000000,    64'h40000000,     1'b0, 33, "mulh_min");
        run(1'b0, DIV,    64'hFFFFFFEC,    64'd3,           64'hFFFFFFFA,     1'b0, 33, "div_m20_3");
        run(1'b0, REM,    64'hFFFFFFEC,    64'd3,           64'hFFFFFFFE,     1'b0, 33, "rem_m20_3");
        run(1'b0, DIVU,   64'd20,          64'd5,           64'd4,            1'b0, 33, "divu20_5");
        run(1'b0, REMU,   64'd20,          64'd5,           64'd0,            1'b0, 33, "remu20_5");
        run(1'b0, DIV,    64'd7,           64'hFFFFFFFE,    64'hFFFFFFFD,     1'b0, 33, "div7_m2");
        run(1'b0, REM,    64'd7,           64'hFFFFFFFE,    64'd1,            1'b0, 33, "rem7_m2");
        run(1'b0, DIVU,   64'hFFFFFFFF,    64'd1,           64'hFFFFFFFF,     1'b0, 33, "divu_max_1");

        // Fast path
        run(1'b0, DIVU,   64'd7,           64'd0,           64'hFFFFFFFF,     1'b0, 1,  "divu7_0");
        run(1'b0, REMU,   64'd7,           64'd0,           64'd7,            1'b0, 1,  "remu7_0");
        run(1'b0, REM,    64'h80000000,    64'hFFFFFFFF,    64'd0,            1'b0, 1,  "rem_ovf");
        run(1'b0, DIV,    64'h80000000,    64'hFFFFFFFF,    64'h80000000,     1'b0, 1,  "div_ovf");
        run(1'b0, 6'b000000, 64'd5,        64'd6,           64'd0,            1'b1, 1,  "bad_op");

        // Result held under back-pressure, then back-to-back accept
        ordy32 = 1'b0;
        drive(1'b0, 1'b1, MUL, 64'd15, 64'd10);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, MUL, 64'd99, 64'd99);
        wait_valid(1'b0, lat);
        check("hold/lat", 64'(lat), 64'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold/res", get_res(1'b0), 64'd150);
            check("hold/in_ready", 64'(ir32), 64'd0);
            check("hold/out_valid", 64'(ov32), 64'd1);
        end
        drive(1'b0, 1'b1, DIVU, 64'd20, 64'd5);
        ordy32 = 1'b1;
        @(posedge clk); #1;
        check("b2b/valid_dropped", 64'(ov32), 64'd0);
        check("b2b/ready_after_consume", 64'(ir32), 64'd1);
        @(posedge clk); #1;
        check("b2b/accepted", 64'(ir32), 64'd0);
        drive(1'b0, 1'b0, DIVU, 64'd1, 64'd1);
        wait_valid(1'b0, lat);
        check("b2b/lat", 64'(lat), 64'd33);
        check("b2b/res", get_res(1'b0), 64'd4);
        @(posedge clk); #1;

        // Reset in the 10th CALC cycle aborts the operation
        drive(1'b0, 1'b1, DIVU, 64'd100, 64'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, DIVU, 64'd0, 64'd0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check("abort/out_valid", 64'(ov32), 64'd0);
        check("abort/in_ready", 64'(ir32), 64'd0);
        check("abort/result", get_res(1'b0), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov32) seen++;
        end
        check("abort/no_stale_result", 64'(seen), 64'd0);
        check("abort/ready", 64'(ir32), 64'd1);
        run(1'b0, MUL, 64'd3, 64'd4, 64'd12, 1'b0, 33, "post_abort_mul");

        // WIDTH=8 instance
        run(1'b1, MUL,   64'h80, 64'h80, 64'h00, 1'b0, 9, "w8_mul");
        run(1'b1, MULHU, 64'h80, 64'h80, 64'h40, 1'b0, 9, "w8_mulhu");
        run(1'b1, DIV,   64'h80, 64'hFF, 64'h80, 1'b0, 1, "w8_div_ovf");
        run(1'b1, DIV,   64'h80, 64'h03, 64'hD6, 1'b0, 9, "w8_div");
        run(1'b1, REM,   64'h80, 64'h03, 64'hFE, 1'b0, 9, "w8_rem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
